// File: rtl/cla_pkg.sv
// cla_pkg: shared helpers for the pipelined carry-lookahead adder/subtractor
package cla_pkg;
    // One pipeline stage per SEG-bit segment
    function automatic int stage_count(input int n, input int seg);
        return n / seg;
    endfunction
endpackage

// File: rtl/cla_seg.sv
// cla_seg: combinational SEG-bit carry-lookahead segment
//   a, b   : segment operands (b already inverted for subtraction)
//   cin    : carry into bit 0 of the segment
//   sum    : segment sum
//   cout   : carry out of the segment MSB
//   c_msb  : carry into the segment MSB (used for signed overflow)
module cla_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    logic [SEG-1:0] g, p;
    logic [SEG:0]   c;
    logic           pp;
    assign g = a & b;
    assign p = a ^ b;
    // Each carry is the flat OR of generate terms masked by the propagate run above them
    always_comb begin
        c = '0;
        pp = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end
    assign sum   = p ^ c[SEG-1:0];
    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: pipelined CLA adder/subtractor with valid/ready handshake
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_ready = pipeline may advance)
//   in_sub, in_x, in_y   : 0 = x+y, 1 = x-y
//   out_valid/out_ready  : result handshake
//   out_sum, out_carry   : result and carry out of bit N-1
//   out_ovf, out_zero    : signed overflow, result-is-zero
// Optional SATURATE_EN: clamp out_sum to the signed range on overflow.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_carry,
    output logic         out_ovf,
    output logic         out_zero
);
    localparam int STG = stage_count(N, SEG);

    // Token travelling down the pipe: lower sum segments fill in as it goes
    typedef struct packed {
        logic         valid;
        logic         carry;
        logic         cm;
        logic         zero;
        logic [N-1:0] sum;
        logic [N-1:0] x;
        logic [N-1:0] y;
    } tok_t;

    if (N < 2 || SEG < 1 || N % SEG != 0) begin : g_bad
        $error("pipelined_cla_addsub: N must be >= 2 and a multiple of SEG");
    end

    logic adv;

    for (genvar k = 0; k < STG; k++) begin : g_stg
        tok_t           src, nxt, q;
        logic [SEG-1:0] s;
        logic           co, cm;
        if (k == 0) begin : g_in
            always_comb begin
                src = '0;
                src.valid = in_valid;
                src.carry = in_sub;
                src.x = in_x;
                src.y = in_y ^ {N{in_sub}};
            end
        end else begin : g_mid
            assign src = g_stg[k-1].q;
        end
        cla_seg #(.SEG(SEG)) u_seg (
            .a     (src.x[k*SEG +: SEG]),
            .b     (src.y[k*SEG +: SEG]),
            .cin   (src.carry),
            .sum   (s),
            .cout  (co),
            .c_msb (cm)
        );
        always_comb begin
            nxt = src;
            nxt.sum[k*SEG +: SEG] = s;
            nxt.carry = co;
            nxt.cm = cm;
            if (k == STG - 1) begin
`ifdef SATURATE_EN
                // Overflow only happens when both effective operands share x's sign
                if (cm ^ co) nxt.sum = {src.x[N-1], {(N-1){~src.x[N-1]}}};
`endif
                nxt.zero = (nxt.sum == '0);
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else if (adv) q <= nxt;
        end
    end

    assign adv       = !g_stg[STG-1].q.valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = g_stg[STG-1].q.valid;
    assign out_sum   = g_stg[STG-1].q.sum;
    assign out_carry = g_stg[STG-1].q.carry;
    assign out_ovf   = g_stg[STG-1].q.cm ^ g_stg[STG-1].q.carry;
    assign out_zero  = g_stg[STG-1].q.zero;
endmodule
